// File: rtl/mmio_pkg.sv
// Shared register map, STATUS bit positions and decode helper for the MMIO port block.
// The timer registers only decode when MMIO_TIMER_EN is defined.
package mmio_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1001_0024;

    localparam logic [31:0] OFF_PORTOUT = 32'h0000_0000;
    localparam logic [31:0] OFF_PORTIN  = 32'h0000_0004;
    localparam logic [31:0] OFF_STATUS  = 32'h0000_0008;
    localparam logic [31:0] OFF_TLOAD   = 32'h0000_000C;
    localparam logic [31:0] OFF_TCOUNT  = 32'h0000_0010;

    localparam int STAT_CHG = 0;
    localparam int STAT_EXP = 1;
    localparam int STAT_TEN = 2;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_PORTOUT,
        SEL_PORTIN,
        SEL_STATUS,
        SEL_TLOAD,
        SEL_TCOUNT
    } regSel_e;

    function automatic regSel_e decodeOffset(input logic [31:0] off);
        regSel_e s;
        unique case (off)
            OFF_PORTOUT: s = SEL_PORTOUT;
            OFF_PORTIN:  s = SEL_PORTIN;
            OFF_STATUS:  s = SEL_STATUS;
            OFF_TLOAD:   s = SEL_TLOAD;
            OFF_TCOUNT:  s = SEL_TCOUNT;
            default:     s = SEL_NONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// Periodic 32-bit down counter with reload register and 1->0 expire pulse.
// A load always wins over counting; a zero reload parks the counter at 0.
module mmio_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] loadValue,
    input  logic        enable,
    output logic [31:0] count,
    output logic [31:0] reload,
    output logic        expire
);

    logic [31:0] countQ;
    logic [31:0] reloadQ;

    assign count  = countQ;
    assign reload = reloadQ;

    // High on the edge at which the counter steps from 1 to 0.
    assign expire = enable && !load && (countQ == 32'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            countQ  <= '0;
            reloadQ <= '0;
        end else if (load) begin
            countQ  <= loadValue;
            reloadQ <= loadValue;
        end else if (enable) begin
            if (countQ != 32'd0)
                countQ <= countQ - 32'd1;
            else
                countQ <= reloadQ;
        end
    end

endmodule

// File: rtl/mmio_port_responder.sv
// Memory-mapped I/O responder: output port, synchronized input port, sticky status.
// Define MMIO_TIMER_EN to include the periodic timer (TIMER_LOAD/COUNT, EXP, TEN).
module mmio_port_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = MMIO_BASE_DEFAULT,
    parameter int          PORT_IN_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              Address,
    input  logic [31:0]              WriteData,
    input  logic                     MemWrite,
    input  logic                     MemRead,
    input  logic [PORT_IN_WIDTH-1:0] PortIn,
    output logic [31:0]              ReadData,
    output logic                     IOHit,
    output logic [31:0]              PortOut,
    output logic                     Irq
);

    logic [31:0] offset;
    regSel_e     rawSel;
    regSel_e     sel;

    logic        wrPortOut;
    logic        wrStatus;

    logic [PORT_IN_WIDTH-1:0] syncQ1;
    logic [PORT_IN_WIDTH-1:0] syncQ2;
    logic [PORT_IN_WIDTH-1:0] prevQ;

    logic [31:0] portOutQ;
    logic        chgFlag;
    logic        chgSet;
    logic        tenFlag;
    logic        expFlag;
    logic [31:0] timerCount;
    logic [31:0] timerReload;
    logic [31:0] statusWord;

    assign offset = Address - BASE_ADDR;
    assign rawSel = decodeOffset(offset);

    always_comb begin
        sel = SEL_NONE;
        if ((MemRead || MemWrite) && (Address[1:0] == 2'b00)) begin
            sel = rawSel;
`ifndef MMIO_TIMER_EN
            if (rawSel == SEL_TLOAD || rawSel == SEL_TCOUNT)
                sel = SEL_NONE;
`endif
        end
    end

    assign IOHit     = (sel != SEL_NONE);
    assign wrPortOut = MemWrite && (sel == SEL_PORTOUT);
    assign wrStatus  = MemWrite && (sel == SEL_STATUS);

    // CHG fires one edge after the synchronized value moves.
    assign chgSet = (syncQ2 != prevQ);

    always_ff @(posedge clk) begin
        if (reset) begin
            syncQ1   <= '0;
            syncQ2   <= '0;
            prevQ    <= '0;
            portOutQ <= '0;
            chgFlag  <= 1'b0;
        end else begin
            syncQ1 <= PortIn;
            syncQ2 <= syncQ1;
            prevQ  <= syncQ2;
            if (wrPortOut)
                portOutQ <= WriteData;
            chgFlag <= chgSet
                     | (chgFlag & ~(wrStatus & WriteData[STAT_CHG]));
        end
    end

`ifdef MMIO_TIMER_EN
    logic wrTLoad;
    logic expPulse;

    assign wrTLoad = MemWrite && (sel == SEL_TLOAD);

    mmio_timer uTimer (
        .clk       (clk),
        .reset     (reset),
        .load      (wrTLoad),
        .loadValue (WriteData),
        .enable    (tenFlag),
        .count     (timerCount),
        .reload    (timerReload),
        .expire    (expPulse)
    );

    // A fresh expiry beats a simultaneous write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            tenFlag <= 1'b0;
            expFlag <= 1'b0;
        end else begin
            if (wrStatus)
                tenFlag <= WriteData[STAT_TEN];
            expFlag <= expPulse
                     | (expFlag & ~(wrStatus & WriteData[STAT_EXP]));
        end
    end
`else
    assign tenFlag     = 1'b0;
    assign expFlag     = 1'b0;
    assign timerCount  = '0;
    assign timerReload = '0;
`endif

    always_comb begin
        statusWord           = '0;
        statusWord[STAT_CHG] = chgFlag;
        statusWord[STAT_EXP] = expFlag;
        statusWord[STAT_TEN] = tenFlag;
    end

    always_comb begin
        ReadData = '0;
        if (MemRead) begin
            unique case (sel)
                SEL_PORTOUT: ReadData = portOutQ;
                SEL_PORTIN:  ReadData = 32'(syncQ2);
                SEL_STATUS:  ReadData = statusWord;
                SEL_TLOAD:   ReadData = timerReload;
                SEL_TCOUNT:  ReadData = timerCount;
                default:     ReadData = '0;
            endcase
        end
    end

    assign PortOut = portOutQ;
    assign Irq     = chgFlag | expFlag;

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed self-checking bench for mmio_port_responder.
// Timer checks run when MMIO_TIMER_EN is defined; otherwise the stripped build is checked.
module tb_mmio_port_responder;

    localparam logic [31:0] A_OUT  = 32'h1001_0024;
    localparam logic [31:0] A_IN   = 32'h1001_0028;
    localparam logic [31:0] A_STAT = 32'h1001_002C;
    localparam logic [31:0] A_TLD  = 32'h1001_0030;
    localparam logic [31:0] A_TCNT = 32'h1001_0034;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [7:0]  PortIn;
    logic [31:0] ReadData;
    logic        IOHit;
    logic [31:0] PortOut;
    logic        Irq;

    int nChecks = 0;
    int nErrors = 0;

    mmio_port_responder dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .PortIn    (PortIn),
        .ReadData  (ReadData),
        .IOHit     (IOHit),
        .PortOut   (PortOut),
        .Irq       (Irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        Address   = a;
        WriteData = d;
        MemWrite  = 1'b1;
        @(negedge clk);
        MemWrite  = 1'b0;
        WriteData = '0;
    endtask

    task automatic readReg(input string tag,
                           input logic [31:0] a,
                           input logic [31:0] exp,
                           input logic expHit);
        Address = a;
        MemRead = 1'b1;
        #1;
        check({tag, ".data"}, ReadData, exp);
        check({tag, ".hit"}, {31'b0, IOHit}, {31'b0, expHit});
        MemRead = 1'b0;
    endtask

    task automatic resetWithStore();
        reset     = 1'b1;
        Address   = A_OUT;
        WriteData = 32'h1234_5678;
        MemWrite  = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        MemWrite = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        Address   = '0;
        WriteData = '0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        PortIn    = 8'h00;
        step();
        step();
        reset = 1'b0;

        check("rst.portout", PortOut, 32'h0);
        check("rst.irq", {31'b0, Irq}, 32'h0);
        readReg("rst.portin", A_IN, 32'h0, 1'b1);
        readReg("rst.status", A_STAT, 32'h0, 1'b1);

        store(A_OUT, 32'hDEAD_BEEF);
        check("wr.portout", PortOut, 32'hDEAD_BEEF);
        readReg("rd.portout", A_OUT, 32'hDEAD_BEEF, 1'b1);

        PortIn = 8'h5A;
        step();
        readReg("sync.e1", A_IN, 32'h0, 1'b1);
        step();
        readReg("sync.e2", A_IN, 32'h5A, 1'b1);
        check("chg.e2.irq", {31'b0, Irq}, 32'h0);
        step();
        check("chg.e3.irq", {31'b0, Irq}, 32'h1);
        readReg("chg.e3.stat", A_STAT, 32'h1, 1'b1);
        step();
        readReg("chg.sticky", A_STAT, 32'h1, 1'b1);
        store(A_STAT, 32'h1);
        readReg("chg.w1c", A_STAT, 32'h0, 1'b1);
        check("chg.w1c.irq", {31'b0, Irq}, 32'h0);

        readReg("mis.26", 32'h1001_0026, 32'h0, 1'b0);
        readReg("oor.40", 32'h1001_0040, 32'h0, 1'b0);
        readReg("oor.20", 32'h1001_0020, 32'h0, 1'b0);
        store(32'h1001_0026, 32'h1111_1111);
        store(32'h1001_0040, 32'h2222_2222);
        store(32'h1001_0025, 32'h3333_3333);
        check("bad.wr.portout", PortOut, 32'hDEAD_BEEF);
        store(A_IN, 32'hFFFF_FFFF);
        readReg("ro.portin", A_IN, 32'h5A, 1'b1);

`ifdef MMIO_TIMER_EN
        store(A_STAT, 32'h4);
        readReg("t.ten", A_STAT, 32'h4, 1'b1);
        store(A_TLD, 32'h3);
        readReg("t.c3", A_TCNT, 32'h3, 1'b1);
        readReg("t.reload", A_TLD, 32'h3, 1'b1);
        step();
        readReg("t.c2", A_TCNT, 32'h2, 1'b1);
        step();
        readReg("t.c1", A_TCNT, 32'h1, 1'b1);
        check("t.c1.irq", {31'b0, Irq}, 32'h0);
        step();
        readReg("t.c0", A_TCNT, 32'h0, 1'b1);
        readReg("t.exp", A_STAT, 32'h6, 1'b1);
        check("t.exp.irq", {31'b0, Irq}, 32'h1);
        step();
        readReg("t.reld", A_TCNT, 32'h3, 1'b1);
        step();
        step();
        step();
        readReg("t.p2.c0", A_TCNT, 32'h0, 1'b1);
        step();
        readReg("t.p2.reld", A_TCNT, 32'h3, 1'b1);
        store(A_STAT, 32'h6);
        readReg("t.clr.stat", A_STAT, 32'h4, 1'b1);
        readReg("t.clr.c2", A_TCNT, 32'h2, 1'b1);
        step();
        readReg("t.race.c1", A_TCNT, 32'h1, 1'b1);
        store(A_STAT, 32'h6);
        readReg("t.race.c0", A_TCNT, 32'h0, 1'b1);
        readReg("t.race.stat", A_STAT, 32'h6, 1'b1);
        store(A_STAT, 32'h6);
        readReg("t.clr2.c3", A_TCNT, 32'h3, 1'b1);
        readReg("t.clr2.stat", A_STAT, 32'h4, 1'b1);

        store(A_TLD, 32'h0);
        step();
        step();
        readReg("t.z.c", A_TCNT, 32'h0, 1'b1);
        readReg("t.z.stat", A_STAT, 32'h4, 1'b1);

        store(A_OUT, 32'h0000_00FF);
        store(A_TLD, 32'h5);
        step();
        readReg("t.pre.c4", A_TCNT, 32'h4, 1'b1);
        resetWithStore();
        check("r.portout", PortOut, 32'h0);
        check("r.irq", {31'b0, Irq}, 32'h0);
        readReg("r.count", A_TCNT, 32'h0, 1'b1);
        readReg("r.reload", A_TLD, 32'h0, 1'b1);
        readReg("r.stat", A_STAT, 32'h0, 1'b1);
        store(A_TLD, 32'h2);
        step();
        readReg("r.ten0", A_TCNT, 32'h2, 1'b1);
`else
        readReg("nt.tld", A_TLD, 32'h0, 1'b0);
        readReg("nt.tcnt", A_TCNT, 32'h0, 1'b0);
        store(A_STAT, 32'h6);
        readReg("nt.stat", A_STAT, 32'h0, 1'b1);
        PortIn = 8'hA5;
        step();
        step();
        step();
        check("nt.irq", {31'b0, Irq}, 32'h1);
        store(A_STAT, 32'h7);
        readReg("nt.w1c", A_STAT, 32'h0, 1'b1);
        check("nt.irq0", {31'b0, Irq}, 32'h0);
        store(A_OUT, 32'h0000_00FF);
        resetWithStore();
        check("r.portout", PortOut, 32'h0);
        readReg("r.portin", A_IN, 32'h0, 1'b1);
        readReg("r.stat", A_STAT, 32'h0, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/mmio_port_responder.md
MMIO_PORT_RESPONDER -- requirements
Module: mmio_port_responder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1001_0024, SHALL be the byte address of the first I/O register.
REQ-002 Parameter PORT_IN_WIDTH, default 8, SHALL be the width of the external input port.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 Address  input  32  SHALL be the processor data-bus byte address.
REQ-006 WriteData  input  32  SHALL be the processor store data.
REQ-007 MemWrite  input  1  SHALL be the processor store strobe.
REQ-008 MemRead  input  1  SHALL be the processor load strobe.
REQ-009 PortIn  input  PORT_IN_WIDTH  SHALL be the asynchronous external input port.
REQ-010 ReadData  output  32  SHALL be the load data for an I/O hit, 0 otherwise.
REQ-011 IOHit  output  1  SHALL indicate the current access targets this block; the processor top selects ReadData over RAM data with it.
REQ-012 PortOut  output  32  SHALL be the registered output port.
REQ-013 Irq  output  1  SHALL be the OR of the enabled sticky status flags.

Function
REQ-014 Register map, word offsets from BASE_ADDR: 0x0 PORTOUT (RW), 0x4 PORTIN (RO), 0x8 STATUS (RW), 0xC TIMER_LOAD (RW), 0x10 TIMER_COUNT (RO).
REQ-015 IOHit SHALL be 1 only when (MemRead|MemWrite)=1, Address[1:0]=0 and Address is one of the five offsets; misaligned or out-of-range accesses SHALL have no effect.
REQ-016 ReadData SHALL be combinational from current register state (zero latency), matching single-cycle load timing.
REQ-017 Stores SHALL take effect at the rising edge on which MemWrite and the matching address are sampled; writes to RO registers SHALL be ignored.
REQ-018 PortIn SHALL pass a 2-flop synchronizer; PORTIN read SHALL return the synchronized value zero-extended (2-cycle input latency).
REQ-019 STATUS bit0 CHG SHALL set on the edge after the synchronized value differs from its previous-cycle value.
REQ-020 STATUS bit1 EXP SHALL set when the timer counts from 1 to 0; bit2 TEN is the timer enable; bits 31:3 read 0.
REQ-021 STATUS write: bit2 SHALL load TEN; a 1 in bit0/bit1 SHALL clear CHG/EXP (write-1-to-clear); set and clear in the same cycle SHALL leave the flag set.
REQ-022 TIMER_LOAD write SHALL load both the reload register and the 32-bit down counter; load SHALL take priority over decrement.
REQ-023 With TEN=1 and counter nonzero the counter SHALL decrement by 1 per cycle; on reaching 0 it SHALL reload from the reload register next cycle (periodic); reload value 0 SHALL leave the counter at 0 with no further EXP.
REQ-024 Irq SHALL equal CHG | EXP, registered flags, no extra latency.

Reset
REQ-025 On reset=1 at a clock edge: PortOut=0, synchronizer and previous-value flops=0, CHG=EXP=TEN=0, reload=counter=0.
REQ-026 Reset SHALL override any simultaneous store; a reset mid-count SHALL stop and zero the timer.

Configuration
REQ-027 Macro MMIO_TIMER_EN defined SHALL include the timer (TIMER_LOAD, TIMER_COUNT, EXP, TEN).
REQ-028 Without MMIO_TIMER_EN, offsets 0xC/0x10 SHALL not hit, STATUS bits 2:1 SHALL read 0 and ignore writes, Irq=CHG.

Structure
REQ-029 Register offsets, STATUS bit indices and BASE_ADDR default SHALL live in a shared package mmio_pkg.
REQ-030 The timer SHALL be a sub-module mmio_timer (load, enable, count, expire pulse); decode and flags stay in the top.

Verification
REQ-031 Store 0xDEAD_BEEF to 0x1001_0024 -> PortOut=0xDEAD_BEEF next edge; load same address -> ReadData=0xDEAD_BEEF, IOHit=1.
REQ-032 PortIn 0x00->0x5A -> PORTIN reads 0x5A from 2nd edge, CHG=1 and Irq=1 on 3rd edge; store 0x1 to STATUS -> CHG=0.
REQ-033 Store 0x4 to STATUS, 3 to TIMER_LOAD -> COUNT 3,2,1,0, EXP=1 at 0, COUNT=3 next cycle, repeating.
REQ-034 STATUS W1C of EXP on the exact cycle of a new 1->0 expiry -> EXP remains 1.
REQ-035 Load from 0x1001_0026 or 0x1001_0040 -> IOHit=0, ReadData=0; store there -> no register change.
REQ-036 Assert reset while counting with PortOut=0xFF -> all outputs and registers 0 next edge; build without MMIO_TIMER_EN -> TIMER_LOAD access IOHit=0.
